// File: rtl/bram_arbiter.sv
// bram_arbiter: two-master round-robin BRAM arbiter with lockable bursts and pipelined read return
// Ports:
//   aclk, aresetn              clock and synchronous active-low reset
//   mN_req/lock/addr/wrdata/we master N access request (N = 0, 1)
//   mN_gnt                     access accepted this cycle (combinational)
//   mN_rvalid/rddata           read data return, RD_LATENCY cycles after a granted read
//   BRAM_*                     single-port block RAM interface, BRAM_CLK = aclk
//   busy                       grant this cycle or read still in flight
module bram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    parameter int MAX_BURST  = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  m0_req,
    input  logic                  m0_lock,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wrdata,
    input  logic [3:0]            m0_we,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rddata,
    input  logic                  m1_req,
    input  logic                  m1_lock,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wrdata,
    input  logic [3:0]            m1_we,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rddata,
    output logic [ADDR_WIDTH-1:0] BRAM_ADDR,
    output logic [DATA_WIDTH-1:0] BRAM_WRDATA,
    output logic [3:0]            BRAM_WE,
    output logic                  BRAM_EN,
    output logic                  BRAM_CLK,
    input  logic [DATA_WIDTH-1:0] BRAM_RDDATA,
    output logic                  busy
);
    typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_t;
    owner_t                owner;
    logic                  last;
    logic [7:0]            burst;
    logic [RD_LATENCY-1:0] tag_v;
    logic [RD_LATENCY-1:0] tag_id;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wrdata_q;
    logic [DATA_WIDTH-1:0] rd0_q;
    logic [DATA_WIDTH-1:0] rd1_q;
    logic                  own0;
    logic                  own1;
    logic                  at_max;
    logic                  force_rel;
    logic                  rr1;
    logic                  grant;
    // last = 1 means m1 was served most recently, so m0 wins the next tie
    always_comb begin
        own0      = owner == OWN_M0 && m0_req;
        own1      = owner == OWN_M1 && m1_req;
        at_max    = burst == 8'(MAX_BURST - 1);
        force_rel = at_max && (own0 ? m1_req : own1 && m0_req);
        rr1       = m1_req && (!m0_req || !last);
        m0_gnt    = aresetn && (own0 ? !force_rel : own1 ? force_rel : m0_req && !rr1);
        m1_gnt    = aresetn && (own1 ? !force_rel : own0 ? force_rel : rr1);
        grant     = m0_gnt || m1_gnt;
    end
    assign BRAM_CLK    = aclk;
    assign BRAM_EN     = grant;
    assign BRAM_WE     = m0_gnt ? m0_we : m1_gnt ? m1_we : 4'b0;
    assign BRAM_ADDR   = m0_gnt ? m0_addr : m1_gnt ? m1_addr : addr_q;
    assign BRAM_WRDATA = m0_gnt ? m0_wrdata : m1_gnt ? m1_wrdata : wrdata_q;
    // the oldest tag lines up with BRAM_RDDATA of the read it was pushed for
    assign m0_rvalid = aresetn && tag_v[RD_LATENCY-1] && !tag_id[RD_LATENCY-1];
    assign m1_rvalid = aresetn && tag_v[RD_LATENCY-1] && tag_id[RD_LATENCY-1];
    assign m0_rddata = m0_rvalid ? BRAM_RDDATA : rd0_q;
    assign m1_rddata = m1_rvalid ? BRAM_RDDATA : rd1_q;
    assign busy      = grant || (aresetn && |tag_v);
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            owner    <= OWN_NONE;
            last     <= 1'b1;
            burst    <= 8'd0;
            tag_v    <= '0;
            tag_id   <= '0;
            addr_q   <= '0;
            wrdata_q <= '0;
            rd0_q    <= '0;
            rd1_q    <= '0;
        end else begin
            owner <= m0_gnt && m0_lock ? OWN_M0 : m1_gnt && m1_lock ? OWN_M1 : OWN_NONE;
            // counts only while the owner keeps the bus; wraps silently when nobody else waits
            burst <= (own0 || own1) && !force_rel && !at_max ? burst + 8'd1 : 8'd0;
            if (grant) last <= m1_gnt;
            for (int i = RD_LATENCY - 1; i > 0; i--) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
            tag_v[0]  <= grant && BRAM_WE == 4'b0;
            tag_id[0] <= m1_gnt;
            addr_q    <= BRAM_ADDR;
            wrdata_q  <= BRAM_WRDATA;
            rd0_q     <= m0_rddata;
            rd1_q     <= m1_rddata;
        end
    end
endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: directed bench with a rule-level arbiter/BRAM model checked every cycle
module tb_bram_arbiter;
    localparam int L  = 3;
    localparam int MB = 16;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        m0_req, m0_lock, m1_req, m1_lock;
    logic [31:0] m0_addr, m1_addr, m0_wrdata, m1_wrdata;
    logic [3:0]  m0_we, m1_we;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rddata, m1_rddata;
    logic [31:0] bram_addr, bram_wrdata, bram_rddata;
    logic [3:0]  bram_we;
    logic        bram_en, bram_clk, busy;
    int          checks = 0;
    int          errors = 0;
    int          cyc_n = 0;

    always #5 aclk = ~aclk;

    bram_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RD_LATENCY(L), .MAX_BURST(MB)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wrdata(m0_wrdata), .m0_we(m0_we),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rddata(m0_rddata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wrdata(m1_wrdata), .m1_we(m1_we),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rddata(m1_rddata),
        .BRAM_ADDR(bram_addr), .BRAM_WRDATA(bram_wrdata), .BRAM_WE(bram_we), .BRAM_EN(bram_en),
        .BRAM_CLK(bram_clk), .BRAM_RDDATA(bram_rddata), .busy(busy)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // BRAM with L-cycle registered read
    logic [31:0] mem [256];
    logic [31:0] pipe [L];
    always @(posedge aclk) begin
        if (bram_en && |bram_we) mem[bram_addr[7:0]] <= merge(mem[bram_addr[7:0]], bram_wrdata, bram_we);
        pipe[0] <= mem[bram_addr[7:0]];
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign bram_rddata = pipe[L-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc_n, act, exp);
        end
    endtask

    // reference model state
    typedef struct { int due; int m; logic [31:0] d; } rd_t;
    rd_t         q[$];
    logic [31:0] ref_mem [256];
    int          holder = -1, held = 0, last = 1;
    logic [31:0] exp_rd0 = 0, exp_rd1 = 0, last_addr = 0, last_wd = 0;
    logic        prev_rst = 1'b1;
    int          glog[$], rvlog[$];
    logic [3:0]  welog[$];
    logic [31:0] rd0log[$], rd1log[$];

    initial for (int i = 0; i < 256; i++) begin
        mem[i]     = 32'hC0DE0000 | i;
        ref_mem[i] = 32'hC0DE0000 | i;
    end

    always @(negedge aclk) begin : cmp
        int          eg, er;
        logic [31:0] ea, ew;
        logic [3:0]  ewe;
        logic        other;
        glog.push_back(m0_gnt ? 0 : m1_gnt ? 1 : -1);
        rvlog.push_back(m0_rvalid ? 0 : m1_rvalid ? 1 : -1);
        welog.push_back(bram_we);
        rd0log.push_back(m0_rddata);
        rd1log.push_back(m1_rddata);
        if (!aresetn) begin
            chk("rst_gnt", {m0_gnt, m1_gnt}, 0);
            chk("rst_en_we", {bram_en, bram_we}, 0);
            chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
            chk("rst_busy", busy, 0);
            if (prev_rst) begin
                chk("rst_rddata", {m0_rddata, m1_rddata}, 0);
                chk("rst_bram_addr", {bram_addr, bram_wrdata}, 0);
            end
            holder = -1; held = 0; last = 1; q.delete();
            exp_rd0 = 0; exp_rd1 = 0; last_addr = 0; last_wd = 0;
        end else begin
            eg = -1;
            if (holder >= 0 && (holder == 0 ? m0_req : m1_req)) begin
                other = holder == 0 ? m1_req : m0_req;
                eg = (held == MB - 1 && other) ? 1 - holder : holder;
            end else if (m0_req && m1_req) eg = 1 - last;
            else if (m0_req) eg = 0;
            else if (m1_req) eg = 1;
            ea  = eg == 0 ? m0_addr : eg == 1 ? m1_addr : last_addr;
            ew  = eg == 0 ? m0_wrdata : eg == 1 ? m1_wrdata : last_wd;
            ewe = eg == 0 ? m0_we : eg == 1 ? m1_we : 4'b0;
            er = -1;
            if (q.size() > 0 && q[0].due == cyc_n) begin
                er = q[0].m;
                if (er == 0) exp_rd0 = q[0].d; else exp_rd1 = q[0].d;
            end
            chk("m0_gnt", m0_gnt, eg == 0);
            chk("m1_gnt", m1_gnt, eg == 1);
            chk("bram_en", bram_en, eg >= 0);
            chk("bram_we", bram_we, ewe);
            chk("bram_addr", bram_addr, ea);
            chk("bram_wrdata", bram_wrdata, ew);
            chk("m0_rvalid", m0_rvalid, er == 0);
            chk("m1_rvalid", m1_rvalid, er == 1);
            chk("m0_rddata", m0_rddata, exp_rd0);
            chk("m1_rddata", m1_rddata, exp_rd1);
            chk("busy", busy, eg >= 0 || q.size() > 0);
            if (er >= 0) void'(q.pop_front());
            held = (eg >= 0 && eg == holder) ? (held == MB - 1 ? 0 : held + 1) : 0;
            holder = (eg >= 0 && (eg == 0 ? m0_lock : m1_lock)) ? eg : -1;
            if (eg >= 0) begin
                last = eg;
                if (ewe == 4'b0) q.push_back('{cyc_n + L, eg, ref_mem[ea[7:0]]});
                else ref_mem[ea[7:0]] = merge(ref_mem[ea[7:0]], ew, ewe);
            end
            last_addr = ea;
            last_wd = ew;
        end
        prev_rst = !aresetn;
        cyc_n++;
    end

    task automatic set0(input logic r, input logic l, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        m0_req = r; m0_lock = l; m0_addr = a; m0_wrdata = d; m0_we = w;
    endtask
    task automatic set1(input logic r, input logic l, input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        m1_req = r; m1_lock = l; m1_addr = a; m1_wrdata = d; m1_we = w;
    endtask
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask
    task automatic idle(input int n);
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        tick(n);
    endtask

    initial begin
        int s, n, run, mx;
        idle(3);
        aresetn = 1'b1;
        // no traffic: no grants anywhere
        s = glog.size();
        idle(10);
        n = 0;
        for (int i = s; i < s + 10; i++) if (glog[i] != -1) n++;
        chk("idle_no_grant", n, 0);
        // plain round robin reads
        s = glog.size();
        set0(1, 0, 32'h20, 0, 0);
        set1(1, 0, 32'h30, 0, 0);
        tick(4);
        idle(L + 2);
        for (int i = 0; i < 4; i++) chk("rr_seq", glog[s+i], i % 2);
        for (int i = 0; i < 4; i++) chk("rr_rvalid_seq", rvlog[s+L+i], i % 2);
        chk("rr_m0_data", rd0log[s+L], 32'hC0DE0020);
        chk("rr_m1_data", rd1log[s+L+1], 32'hC0DE0030);
        // locked m0 against waiting m1
        s = glog.size();
        set0(1, 1, 32'h21, 0, 0);
        set1(1, 0, 32'h31, 0, 0);
        tick(40);
        idle(L + 2);
        n = 0;
        for (int i = s; i < s + 16; i++) if (glog[i] == 0) n++;
        chk("burst_m0_grants", n, 16);
        chk("burst_m1_turn", glog[s+16], 1);
        chk("burst_m0_reacquire", glog[s+17], 0);
        run = 0; mx = 0;
        for (int i = s; i < s + 40; i++) begin
            run = glog[i] == 1 ? 0 : run + 1;
            if (run > mx) mx = run;
        end
        chk("burst_m1_max_wait", mx, 16);
        // locked m0 alone: no forced release
        s = glog.size();
        set0(1, 1, 32'h22, 0, 0);
        tick(20);
        idle(L + 2);
        n = 0;
        for (int i = s; i < s + 20; i++) if (glog[i] == 0) n++;
        chk("solo_lock_grants", n, 20);
        // write then read back, full and partial byte enables
        s = glog.size();
        set1(1, 0, 32'h10, 32'hDEADBEEF, 4'hF);
        tick(1);
        set1(0, 0, 0, 0, 0);
        set0(1, 0, 32'h10, 0, 0);
        tick(1);
        set0(0, 0, 0, 0, 0);
        set1(1, 0, 32'h10, 32'h11223344, 4'b0101);
        tick(1);
        set1(0, 0, 0, 0, 0);
        set0(1, 0, 32'h10, 0, 0);
        tick(1);
        idle(L + 2);
        chk("wr_we_full", welog[s], 4'hF);
        chk("wr_we_partial", welog[s+2], 4'b0101);
        chk("wr_no_rvalid", rvlog[s+L], -1);
        chk("rd_after_wr_valid", rvlog[s+1+L], 0);
        chk("rd_after_wr_data", rd0log[s+1+L], 32'hDEADBEEF);
        chk("rd_hold_data", rd0log[s+2+L], 32'hDEADBEEF);
        chk("rd_partial_data", rd0log[s+3+L], 32'hDE22BE44);
        // locked m1 writer against reading m0
        set0(1, 0, 32'h40, 0, 0);
        set1(1, 1, 32'h40, 32'hA5A50000, 4'hF);
        tick(20);
        idle(L + 2);
        // reset while a read is in flight
        s = glog.size();
        set0(1, 0, 32'h22, 0, 0);
        tick(1);
        set0(0, 0, 0, 0, 0);
        aresetn = 1'b0;
        tick(1);
        aresetn = 1'b1;
        tick(L + 3);
        n = 0;
        for (int i = s + 1; i < s + L + 5; i++) if (rvlog[i] != -1) n++;
        chk("rst_discard_rvalid", n, 0);
        s = glog.size();
        set0(1, 0, 32'h23, 0, 0);
        set1(1, 0, 32'h33, 0, 0);
        tick(1);
        idle(L + 2);
        chk("post_rst_tie", glog[s], 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, 32, data bus width.
REQ-002 SHALL have parameter: ADDR_WIDTH, 32, address bus width.
REQ-003 SHALL have parameter: RD_LATENCY, 1, BRAM read latency in cycles (legal 1..4).
REQ-004 SHALL have parameter: MAX_BURST, 16, max consecutive locked grants while the other master waits (legal 2..256).
REQ-005 SHALL have port: aclk  in  1  single clock; all logic on rising edge.
REQ-006 SHALL have port: aresetn  in  1  reset, synchronous, active-low.
REQ-007 SHALL have ports per master mN (N = 0, 1): mN_req in 1 access request; mN_lock in 1 burst hold request; mN_addr in ADDR_WIDTH; mN_wrdata in DATA_WIDTH; mN_we in 4 byte write enables.
REQ-008 SHALL have ports per master mN: mN_gnt out 1 access accepted this cycle; mN_rvalid out 1 read data valid; mN_rddata out DATA_WIDTH read data.
REQ-009 SHALL have BRAM-side ports: BRAM_ADDR out ADDR_WIDTH; BRAM_WRDATA out DATA_WIDTH; BRAM_WE out 4; BRAM_EN out 1; BRAM_CLK out 1; BRAM_RDDATA in DATA_WIDTH.
REQ-010 SHALL have port: busy  out  1  grant this cycle or read in flight.

Function
REQ-011 SHALL drive BRAM_CLK = aclk directly.
REQ-012 SHALL compute mN_gnt combinationally each cycle; req and gnt both high = access issued that cycle; at most one gnt high per cycle.
REQ-013 SHALL drive BRAM_ADDR/BRAM_WRDATA/BRAM_WE from the granted master and BRAM_EN=1 on a grant cycle; with no grant, BRAM_EN=0, BRAM_WE=0, BRAM_ADDR/BRAM_WRDATA hold previous value.
REQ-014 SHALL keep state: owner (NONE, M0, M1), last-served pointer, burst counter (8 bits), read-tag pipeline of depth RD_LATENCY.
REQ-015 SHALL, with owner NONE: single requester is granted; both requesting -> grant the master not served last (round-robin).
REQ-016 SHALL set owner to the granted master at the edge when mN_req & mN_gnt & mN_lock; otherwise set owner to NONE.
REQ-017 SHALL, with owner = mN and mN_req high: grant mN and increment burst counter, unless counter = MAX_BURST-1 and other master requesting; then grant the other master, set owner NONE, clear counter.
REQ-018 SHALL, with owner = mN and mN_req low: release ownership same cycle, arbitrate per REQ-015, clear counter.
REQ-019 SHALL clear burst counter when owner becomes NONE or other master is not requesting at MAX_BURST-1 (owner continues).
REQ-020 SHALL update last-served pointer to the granted master on every grant.
REQ-021 SHALL push tag {valid = (BRAM_WE==0), master id} into the read pipeline each cycle (valid=0 without grant).
REQ-022 SHALL assert mN_rvalid for exactly one cycle, exactly RD_LATENCY cycles after a granted read by mN, with mN_rddata = BRAM_RDDATA that cycle; writes produce no rvalid.
REQ-023 SHALL hold mN_rddata between rvalid pulses; the non-addressed master's rddata is unchanged.
REQ-024 SHALL return reads in issue order; a new grant in the same cycle as an rvalid is permitted (fully pipelined, 1 access/cycle).
REQ-025 SHALL assert busy when any gnt is high or any pipeline tag is valid.

Reset
REQ-026 SHALL, while aresetn low at a rising edge: owner NONE, last-served = M1 (M0 wins first tie), burst counter 0, all tags invalid.
REQ-027 SHALL hold m0_gnt, m1_gnt, BRAM_EN, BRAM_WE, m0_rvalid, m1_rvalid, busy at 0 and rddata/BRAM_ADDR/BRAM_WRDATA registers at 0 while in reset.
REQ-028 SHALL discard in-flight reads on reset mid-operation: no rvalid after aresetn returns high.

Verification
REQ-029 Both req, no lock, reads, from reset -> gnt sequence m0,m1,m0,m1; each rvalid RD_LATENCY cycles after its grant on the correct master.
REQ-030 m0 lock+req held 40 cycles, m1 req from cycle 0, MAX_BURST=16 -> m0 16 grants, m1 1 grant, m0 re-acquires; m1 never waits >16 cycles.
REQ-031 m0 lock+req for 20 cycles, m1 idle -> 20 consecutive m0 grants, no forced release.
REQ-032 m1 write addr 0x10 data 0xDEADBEEF we 0xF, then m0 read 0x10 -> BRAM_WE=0xF on write cycle, no rvalid for write; m0_rvalid with 0xDEADBEEF after RD_LATENCY.
REQ-033 RD_LATENCY=3, m0 read issued, aresetn low 1 cycle next cycle -> no m0_rvalid afterward; first post-reset tie grants m0.
REQ-034 No requests for 10 cycles -> BRAM_EN=0, BRAM_WE=0, busy=0 throughout.
